// File: rtl/vote_tally.sv
// Tally for a panel of students plus two extra voters (t, p): collect one vote
// per voter per session, then latch majority(student majority, t, p) as G.
module vote_tally #(
   parameter int N_STUDENTS = 3,
   parameter int ID_W       = 3,
   parameter int CNT_W      = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             close,
   input  logic             vote_valid,
   input  logic [ID_W-1:0]  voter_id,
   input  logic             vote_val,
   output logic             busy,
   output logic             done,
   output logic             G,
   output logic [CNT_W-1:0] student_yes,
   output logic             rej
);

   localparam int N_VOTERS = N_STUDENTS + 2;
   localparam int PAD_W    = 2 ** ID_W;

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

   state_t              r_state;
   logic [N_VOTERS-1:0] r_voted;
   logic [CNT_W-1:0]    r_syes;
   logic                r_t_yes;
   logic                r_p_yes;
   logic                r_g;
   logic                r_rej;

   logic                w_busy;
   logic                w_in_range;
   logic                w_is_student;
   logic                w_is_t;
   logic                w_is_p;
   logic [PAD_W-1:0]    w_voted_pad;
   logic                w_dup;
   logic                w_accept;
   logic                w_reject;
   logic [N_VOTERS-1:0] w_voted_next;
   logic [CNT_W-1:0]    w_syes_next;
   logic                w_t_next;
   logic                w_p_next;
   logic                w_sx;
   logic                w_finish;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   assign w_busy       = (r_state == S_COLLECT);
   assign w_in_range   = ({1'b0, voter_id} < (ID_W + 1)'(N_VOTERS));
   assign w_is_student = ({1'b0, voter_id} < (ID_W + 1)'(N_STUDENTS));
   assign w_is_t       = (voter_id == ID_W'(N_STUDENTS));
   assign w_is_p       = (voter_id == ID_W'(N_STUDENTS + 1));

   // Zero-extend the flags so any voter_id indexes safely; out-of-range ids read 0.
   assign w_voted_pad  = PAD_W'(r_voted);
   assign w_dup        = w_voted_pad[voter_id];

   // A start in COLLECT restarts the session and swallows a coincident vote silently.
   assign w_accept     = w_busy & vote_valid & w_in_range & ~w_dup & ~start;
   assign w_reject     = vote_valid & ~(w_busy & start) & (~w_busy | ~w_in_range | w_dup);

   assign w_voted_next = r_voted | (w_accept ? (N_VOTERS'(1) << voter_id) : '0);
   assign w_syes_next  = r_syes + CNT_W'(w_accept & vote_val & w_is_student);
   assign w_t_next     = r_t_yes | (w_accept & vote_val & w_is_t);
   assign w_p_next     = r_p_yes | (w_accept & vote_val & w_is_p);
   assign w_sx         = ({w_syes_next, 1'b0} > (CNT_W + 1)'(N_STUDENTS));
   assign w_finish     = w_busy & ~start & (close | (&w_voted_next));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_voted <= '0;
         r_syes  <= '0;
         r_t_yes <= 1'b0;
         r_p_yes <= 1'b0;
         r_g     <= 1'b0;
         r_rej   <= 1'b0;
      end else begin
         r_rej <= w_reject;
         if (start) begin
            r_state <= S_COLLECT;
            r_voted <= '0;
            r_syes  <= '0;
            r_t_yes <= 1'b0;
            r_p_yes <= 1'b0;
            r_g     <= 1'b0;
         end else if (r_state == S_COLLECT) begin
            r_voted <= w_voted_next;
            r_syes  <= w_syes_next;
            r_t_yes <= w_t_next;
            r_p_yes <= w_p_next;
            // Result uses the counts including a vote accepted this same cycle.
            if (w_finish) begin
               r_state <= S_DONE;
               r_g     <= majority3(w_sx, w_t_next, w_p_next);
            end
         end
      end
   end

   assign busy        = w_busy;
   assign done        = (r_state == S_DONE);
   assign G           = r_g;
   assign student_yes = r_syes;
   assign rej         = r_rej;

endmodule

// File: tb/tb_vote_tally.sv
// Scoreboard bench for vote_tally (N_STUDENTS=3): expected rej pulses and
// session results are queued by the stimulus and checked by a monitor.
module tb_vote_tally;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       close = 1'b0;
   logic       vote_valid = 1'b0;
   logic [2:0] voter_id = '0;
   logic       vote_val = 1'b0;
   logic       busy, done, G, rej;
   logic [2:0] student_yes;

   typedef struct {
      bit is_done;
      bit g;
      int syes;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail = 0;
   logic done_q = 1'b0;

   vote_tally #(.N_STUDENTS(3), .ID_W(3), .CNT_W(3)) dut (
      .clk(clk), .rst(rst), .start(start), .close(close),
      .vote_valid(vote_valid), .voter_id(voter_id), .vote_val(vote_val),
      .busy(busy), .done(done), .G(G), .student_yes(student_yes), .rej(rej)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic expect_rej(input int syes);
      exp_t e;
      e.is_done = 1'b0; e.g = 1'b0; e.syes = syes;
      exp_q.push_back(e);
   endtask

   task automatic expect_done(input bit g, input int syes);
      exp_t e;
      e.is_done = 1'b1; e.g = g; e.syes = syes;
      exp_q.push_back(e);
   endtask

   // Monitor: every rej pulse and every rising edge of done consumes one entry.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         done_q <= 1'b0;
      end else begin
         if (rej) begin
            if (exp_q.size() == 0) chk("unexpected_rej", 1, 0);
            else begin
               e = exp_q.pop_front();
               chk("rej_kind", 0, int'(e.is_done));
               chk("rej_student_yes", int'(student_yes), e.syes);
            end
         end
         if (done && !done_q) begin
            if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
               e = exp_q.pop_front();
               chk("done_kind", 1, int'(e.is_done));
               chk("done_G", int'(G), int'(e.g));
               chk("done_student_yes", int'(student_yes), e.syes);
            end
         end
         done_q <= done;
      end
   end

   task automatic cyc(input logic s, input logic c, input logic vv,
                      input logic [2:0] id, input logic v);
      start = s; close = c; vote_valid = vv; voter_id = id; vote_val = v;
      @(posedge clk); #1;
      start = 0; close = 0; vote_valid = 0;
   endtask

   task automatic do_start();      cyc(1, 0, 0, 3'd0, 0); endtask
   task automatic do_close();      cyc(0, 1, 0, 3'd0, 0); endtask
   task automatic vote(input logic [2:0] id, input logic v); cyc(0, 0, 1, id, v); endtask
   task automatic idle_cycle();    cyc(0, 0, 0, 3'd0, 0); endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_G", int'(G), 0);
      chk("rst_student_yes", int'(student_yes), 0);
      chk("rst_rej", int'(rej), 0);
      rst = 0;
      idle_cycle();

      // Full session, auto-close on the last voter: S=2 yes -> Sx=1, t=1, p=0
      do_start();
      chk("t1_busy", int'(busy), 1);
      vote(3'd0, 1); vote(3'd1, 0); vote(3'd2, 1); vote(3'd3, 1);
      chk("t1_not_done_early", int'(done), 0);
      expect_done(1'b1, 2);
      vote(3'd4, 0);
      chk("t1_done_next_cycle", int'(done), 1);
      chk("t1_busy_low", int'(busy), 0);
      idle_cycle();
      // close in DONE is ignored, result held
      do_close();
      chk("t1_done_held", int'(done), 1);
      chk("t1_G_held", int'(G), 1);

      // One student yes then close: Sx=0, t/p count as no -> G=0
      do_start();
      chk("t2_G_cleared", int'(G), 0);
      vote(3'd0, 1);
      expect_done(1'b0, 1);
      do_close();
      chk("t2_done", int'(done), 1);

      // Duplicate vote rejected, count unchanged
      do_start();
      vote(3'd1, 1);
      expect_rej(1);
      vote(3'd1, 1);
      idle_cycle();
      chk("t3_student_yes", int'(student_yes), 1);
      expect_done(1'b0, 1);
      do_close();

      // Out-of-range ids in COLLECT, then a vote while DONE
      do_start();
      expect_rej(0);
      vote(3'd6, 1);
      expect_rej(0);
      vote(3'd7, 1);
      chk("t4_busy", int'(busy), 1);
      expect_done(1'b0, 0);
      do_close();
      expect_rej(0);
      vote(3'd0, 1);
      idle_cycle();

      // Vote and close together: the t vote is counted -> Sx=1, t=1 -> G=1
      do_start();
      vote(3'd0, 1); vote(3'd1, 1);
      expect_done(1'b1, 2);
      cyc(0, 1, 1, 3'd3, 1);
      chk("t5_done", int'(done), 1);
      chk("t5_G", int'(G), 1);

      // Restart within COLLECT discards the coincident vote without rej
      do_start();
      vote(3'd0, 1);
      cyc(1, 0, 1, 3'd1, 1);
      chk("t6_restart_count", int'(student_yes), 0);
      chk("t6_restart_busy", int'(busy), 1);
      vote(3'd0, 0); vote(3'd1, 1); vote(3'd2, 1); vote(3'd3, 0);
      expect_done(1'b1, 2);
      vote(3'd4, 1);

      // Asynchronous reset mid-session
      do_start();
      vote(3'd0, 1); vote(3'd3, 1);
      #2 rst = 1;
      #1;
      chk("t7_rst_busy", int'(busy), 0);
      chk("t7_rst_done", int'(done), 0);
      chk("t7_rst_G", int'(G), 0);
      chk("t7_rst_student_yes", int'(student_yes), 0);
      @(posedge clk); #1;
      rst = 0;
      idle_cycle();
      chk("t7_no_result_after_rst", int'(done), 0);
      // IDLE: vote rejected, close ignored without rej
      expect_rej(0);
      vote(3'd0, 1);
      do_close();
      idle_cycle();
      chk("t7_idle_after_close", int'(busy), 0);
      do_start();
      chk("t7_new_student_yes", int'(student_yes), 0);
      vote(3'd0, 0); vote(3'd1, 0); vote(3'd2, 0); vote(3'd3, 0);
      expect_done(1'b0, 0);
      vote(3'd4, 0);

      // Drain: every expected event must have been observed within a bounded wait
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle_cycle();
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
